// File: rtl/serial_adder_if.sv
// serial_adder_if: operand/result bundle for the bit-serial adder.
// Carries sub only when SERIAL_ADDER_SUB_EN is defined.
interface serial_adder_if #(
  parameter int WIDTH = 8
) ();
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
`ifdef SERIAL_ADDER_SUB_EN
  logic             sub;
`endif
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             carry_out;

`ifdef SERIAL_ADDER_SUB_EN
  modport master (
    output start, a, b, sub,
    input  busy, done, sum, carry_out
  );
  modport slave (
    input  start, a, b, sub,
    output busy, done, sum, carry_out
  );
`else
  modport master (
    output start, a, b,
    input  busy, done, sum, carry_out
  );
  modport slave (
    input  start, a, b,
    output busy, done, sum, carry_out
  );
`endif
endinterface

// File: rtl/serial_adder.sv
// serial_adder: one full-adder cell plus carry flop, LSB first.
// Optional subtract mode via SERIAL_ADDER_SUB_EN (adds bus.sub).
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  serial_adder_if.slave bus
);
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic {
    IDLE,
    SHIFT
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_sr_q, a_sr_d;
  logic [WIDTH-1:0] b_sr_q, b_sr_d;
  logic [WIDTH-1:0] s_sr_q, s_sr_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic             done_q, done_d;
  logic             sub_q, sub_d;

  logic             start_sub;
  logic             b_bit;
  logic             fa_s;
  logic             fa_c;
  logic [WIDTH:0]   s_ext;

`ifdef SERIAL_ADDER_SUB_EN
  assign start_sub = bus.sub;
`else
  assign start_sub = 1'b0;
`endif

  // single full-adder cell; subtract inverts b and seeds carry with 1
  always_comb begin
    b_bit = b_sr_q[0] ^ sub_q;
    fa_s  = a_sr_q[0] ^ b_bit ^ carry_q;
    fa_c  = (a_sr_q[0] & b_bit)
          | (carry_q & (a_sr_q[0] ^ b_bit));
    s_ext = {fa_s, s_sr_q};
  end

  // next-state: load on accepted start, shift one bit per SHIFT cycle
  always_comb begin
    state_d = state_q;
    a_sr_d  = a_sr_q;
    b_sr_d  = b_sr_q;
    s_sr_d  = s_sr_q;
    sum_d   = sum_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    sub_d   = sub_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          a_sr_d  = bus.a;
          b_sr_d  = bus.b;
          s_sr_d  = '0;
          sub_d   = start_sub;
          carry_d = start_sub;
          cnt_d   = CW'(WIDTH);
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        s_sr_d  = s_ext[WIDTH:1];
        a_sr_d  = a_sr_q >> 1;
        b_sr_d  = b_sr_q >> 1;
        carry_d = fa_c;
        cnt_d   = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d = IDLE;
          done_d  = 1'b1;
          sum_d   = s_ext[WIDTH:1];
          cout_d  = fa_c ^ sub_q;
        end
      end
    endcase
  end

  // state and datapath registers; reset abandons any operation
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_sr_q  <= '0;
      b_sr_q  <= '0;
      s_sr_q  <= '0;
      sum_q   <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      done_q  <= 1'b0;
      sub_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_sr_q  <= a_sr_d;
      b_sr_q  <= b_sr_d;
      s_sr_q  <= s_sr_d;
      sum_q   <= sum_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      done_q  <= done_d;
      sub_q   <= sub_d;
    end
  end

  assign bus.busy      = (state_q == SHIFT);
  assign bus.done      = done_q;
  assign bus.sum       = sum_q;
  assign bus.carry_out = cout_q;
endmodule

// File: doc/serial_adder.md
# serial_adder

Bit-serial adder: captures two WIDTH-bit operands on a start pulse, then adds them one bit per clock, LSB first, through a single full-adder cell and a carry flip-flop. After WIDTH cycles it reports the sum and carry-out with a one-cycle done pulse. It is the additive counterpart of the team's half-subtractor arithmetic cells. It serves as the low-area adder in the arithmetic library.

## Interface
- WIDTH, 8, operand and sum width in bits; legal range 1..32.

- clk  input  1  rising-edge clock.
- rst_n  input  1  one clock; reset is asynchronous and active-low.
- start  input  1  request; sampled only while idle.
- a  input  WIDTH  augend; captured on accepted start.
- b  input  WIDTH  addend; captured on accepted start.
- busy  output  1  high while a serial operation is in progress.
- done  output  1  one-cycle pulse; sum and carry_out are valid.
- sum  output  WIDTH  result; held until the next accepted start completes.
- carry_out  output  1  final carry, or final borrow in subtract mode.

## Operation
- The FSM has two states.
  - IDLE: busy=0. If start=1, load the operand shift registers from a and b, clear the carry flip-flop, load the bit counter with WIDTH, and go to SHIFT.
  - SHIFT: busy=1. Each cycle, full-add a_sr[0], b_sr[0] and carry.
    - Shift the sum bit into the MSB of the sum shift register, shifting right.
    - Shift a_sr and b_sr right and update carry.
    - Decrement the counter.
    - When the counter reaches 1 on this edge, go to IDLE, set done=1, and latch carry_out.
- The bit counter is $clog2(WIDTH+1) bits wide, so WIDTH=1 works (a single SHIFT cycle).
- sum and carry_out change only on the final SHIFT edge. They are never updated partially, and they hold their values through IDLE.
- start while busy=1 is ignored; operands are not re-captured.
- Arithmetic is modulo 2^WIDTH; overflow appears only on carry_out.
- Reset at any time, including mid-operation: return to IDLE, busy=0, done=0, sum=0, carry_out=0, and clear the internal registers. No operation resumes after reset.

## Timing
- Let E0 be the edge where start is accepted.
- Bits are processed on edges E1..E_WIDTH.
- busy is high from just after E0 until just after E_WIDTH.
- done is high for exactly the one cycle between E_WIDTH and E_WIDTH+1.
- Latency is WIDTH+1 edges from start to done; throughput is one operation per WIDTH+1 cycles.
- Back-to-back operation: start held high is accepted at E_WIDTH+1, the first IDLE edge. done is low on that edge, so two done pulses are never adjacent.
- Reset values of all outputs: busy=0, done=0, sum=0, carry_out=0.

## Configuration
- SERIAL_ADDER_SUB_EN defined:
  - Adds input port `sub` (1 bit), captured with the operands on the accepted start.
  - When sub=1: b bits are inverted as they enter the adder, the carry flip-flop initialises to 1, and the result is a−b.
  - In that mode carry_out reports the borrow, i.e. the inverted final carry (1 when a<b).
  - When sub=0, behaviour is identical to the add-only build.
- SERIAL_ADDER_SUB_EN undefined: the `sub` port is absent, the block only adds, and the carry initialises to 0.

## Test plan
- Reset mid-operation: assert rst_n=0 at E3 of an 8-bit add, then release → busy=0, done=0, sum=0x00, carry_out=0 immediately. No done pulse follows until a new start.
- Basic add, WIDTH=8: a=0x3C, b=0x05, one-cycle start → done is a single pulse 9 edges after start, sum=0x41, carry_out=0, busy high for exactly 8 cycles.
- Overflow: a=0xFF, b=0x01 → sum=0x00, carry_out=1. Then a=0xFF, b=0xFF → sum=0xFE, carry_out=1.
- Start ignored while busy: pulse start with a=0x11, b=0x22 at E3 of a running 0x3C+0x05 → result is still 0x41 and only one done pulse occurs. Then hold start high with new operands → the second operation begins at E9 and its done pulse follows 9 edges later.
- WIDTH=1 instance: a=1, b=1 → done on the second edge after start, sum=0, carry_out=1.
- SERIAL_ADDER_SUB_EN build: 0x3C−0x05 with sub=1 → sum=0x37, borrow=0. 0x05−0x3C → sum=0xC9, borrow=1. The same operands with sub=0 → sum=0x41, carry_out=0.
